// File: rtl/rsa_encrypt_stream.sv
// ---------------------------------------------------------------------------
// rsa_encrypt_stream
// Streaming RSA encryptor computing C = M^e mod n with the public key (e, n).
// Exponentiation is right-to-left square-and-multiply. Each modular product
// is a bit-serial interleaved multiply-reduce taking WIDTH cycles.
// Only one message is in flight at a time.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   pub_e      public exponent, sampled at input accept
//   pub_n      modulus, sampled at input accept
//   in_valid   plaintext word valid
//   in_ready   block can accept (IDLE only)
//   in_data    plaintext M
//   out_valid  ciphertext valid, held until accepted
//   out_ready  downstream accepts
//   out_data   ciphertext C
//   out_err    1 = message rejected (n < 2 or M >= n)
//   busy       state is not IDLE
// ---------------------------------------------------------------------------
module rsa_encrypt_stream #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pub_e,
    input  logic [WIDTH-1:0] pub_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    output logic             busy
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_MUL,
        S_SQR,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_x;      // exponent shift register
    logic [WIDTH-1:0] r_n;      // latched modulus
    logic [WIDTH-1:0] r_r;      // running result
    logic [WIDTH-1:0] r_b;      // running base (also holds M until first SQR)
    logic [WIDTH-1:0] r_acc;    // modmul accumulator
    logic [IW-1:0]    r_idx;    // current multiplier bit, MSB first
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_err;
    logic             r_out_valid;

    // Modmul datapath: multiplicand is R in MUL and B in SQR; the multiplier
    // bits always come from B, so MUL computes R*B and SQR computes B*B.
    logic [WIDTH-1:0] w_a;
    logic             w_bit;
    logic [WIDTH+1:0] w_n_ext;
    logic [WIDTH+1:0] w_t1;
    logic [WIDTH+1:0] w_t2;
    logic [WIDTH+1:0] w_t3;
    logic [WIDTH+1:0] w_t4;
    logic [WIDTH-1:0] w_res;
    logic             w_last;
    logic             w_err;

    assign w_a     = (r_state == S_MUL) ? r_r : r_b;
    assign w_bit   = r_b[r_idx];
    assign w_n_ext = {2'b00, r_n};
    assign w_t1    = {1'b0, r_acc, 1'b0};
    assign w_t2    = (w_t1 >= w_n_ext) ? (w_t1 - w_n_ext) : w_t1;
    assign w_t3    = w_t2 + (w_bit ? {2'b00, w_a} : '0);
    assign w_t4    = (w_t3 >= w_n_ext) ? (w_t3 - w_n_ext) : w_t3;
    assign w_res   = w_t4[WIDTH-1:0];
    assign w_last  = (r_idx == '0);
    assign w_err   = (r_n < WIDTH'(2)) || (r_b >= r_n);

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_err   = r_out_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_x         <= '0;
            r_n         <= '0;
            r_r         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_idx       <= '0;
            r_out_data  <= '0;
            r_out_err   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_x     <= pub_e;
                        r_n     <= pub_n;
                        r_b     <= in_data;
                        r_r     <= WIDTH'(1);
                        r_state <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    r_acc <= '0;
                    r_idx <= IW'(WIDTH - 1);
                    if (w_err) begin
                        r_out_data  <= '0;
                        r_out_err   <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (r_x == '0) begin
                        r_out_data  <= WIDTH'(1);
                        r_out_err   <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (r_x[0]) begin
                        r_state <= S_MUL;
                    end else begin
                        r_state <= S_SQR;
                    end
                end

                S_MUL: begin
                    if (w_last) begin
                        r_r   <= w_res;
                        r_acc <= '0;
                        r_idx <= IW'(WIDTH - 1);
                        if (r_x[WIDTH-1:1] != '0) begin
                            r_state <= S_SQR;
                        end else begin
                            r_out_data  <= w_res;
                            r_out_err   <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end else begin
                        r_acc <= w_res;
                        r_idx <= r_idx - 1'b1;
                    end
                end

                S_SQR: begin
                    if (w_last) begin
                        r_b   <= w_res;
                        r_x   <= r_x >> 1;
                        r_acc <= '0;
                        r_idx <= IW'(WIDTH - 1);
                        // r_x[1] is bit 0 of the shifted exponent
                        r_state <= r_x[1] ? S_MUL : S_SQR;
                    end else begin
                        r_acc <= w_res;
                        r_idx <= r_idx - 1'b1;
                    end
                end

                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
